// File: rtl/adc_spi_capture_if.sv
`timescale 1ns/1ps
// adc_spi_capture_if: sample stream from the ADC capture block to the UART transmitter.
// master drives the sample and its status flags; slave returns sample_ready.
interface adc_spi_capture_if;
    logic [13:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        overrun;

    modport master (
        output sample_data,
        output sample_valid,
        output overrun,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        input  overrun,
        output sample_ready
    );
endinterface

// File: rtl/adc_spi_capture.sv
`timescale 1ns/1ps
// adc_spi_capture: SPI front end for the PGA/ADC pair.
// Optionally programs the amplifier gain after reset, then loops conversion frames forever:
// pulse ADC_Conv, clock 34 SPI_CLK cycles, capture channel A and publish it on a valid/ready
// stream. Optional build macro ADC_AMP_INIT_EN enables the post-reset amplifier load.
module adc_spi_capture #(
    parameter int unsigned CLK_DIV  = 8,
    parameter logic [7:0]  AMP_GAIN = 8'h11,
    parameter int unsigned CONV_GAP = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MISO,
    output logic              MOSI,
    output logic              SPI_CLK,
    output logic              CS_AMP,
    output logic              ADC_Conv,
    adc_spi_capture_if.master smp
);

    typedef enum logic [2:0] {
        StAmpLoad,
        StAmpEnd,
        StConv,
        StShift,
        StPublish,
        StGap
    } state_e;

`ifdef ADC_AMP_INIT_EN
    localparam state_e StReset = StAmpLoad;
`else
    localparam state_e StReset = StConv;
`endif

    localparam logic [7:0]      DivLast = 8'(CLK_DIV - 1);
    localparam int unsigned     GapW    = (CONV_GAP > 1) ? $clog2(CONV_GAP) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(CONV_GAP - 1);

    state_e          state_q, state_d;
    logic            run_q;
    logic [7:0]      div_q, div_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            sclk_q, sclk_d;
    logic            conv_q, conv_d;
    logic [13:0]     cap_q, cap_d;
    logic [13:0]     data_q, data_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;
    logic            tick;
    logic            sclk_toggle;
    logic            state_chg;
    logic [5:0]      bit_idx;

    // run_q holds the divider for the first cycle out of reset, so the reset-entered state
    // gets its full length measured from the first edge, like any other state entry.
    assign tick    = run_q && (div_q == DivLast);
    // cnt_q counts SPI_CLK half-periods in SHIFT; the bit number is half of it.
    assign bit_idx = cnt_q[6:1];

    // FSM next state, SPI_CLK toggle request and MISO capture.
    always_comb begin
        state_d     = state_q;
        sclk_toggle = 1'b0;
        cap_d       = cap_q;
        unique case (state_q)
`ifdef ADC_AMP_INIT_EN
            StAmpLoad: begin
                // 16 toggling ticks, then one extra half-period of CS hold before AMP_END.
                if (tick) begin
                    if (cnt_q == 7'd16) begin
                        state_d = StAmpEnd;
                    end else begin
                        sclk_toggle = 1'b1;
                    end
                end
            end
            StAmpEnd: begin
                if (tick && cnt_q == 7'd1) begin
                    state_d = StConv;
                end
            end
`endif
            StConv: begin
                if (tick && cnt_q == 7'd1) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (tick) begin
                    sclk_toggle = 1'b1;
                    // Falling tick: capture only the channel A bits 2..15.
                    if (sclk_q && bit_idx >= 6'd2 && bit_idx <= 6'd15) begin
                        cap_d = {cap_q[12:0], MISO};
                    end
                    if (cnt_q == 7'd67) begin
                        state_d = StPublish;
                    end
                end
            end
            StPublish: state_d = StGap;
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StConv;
                end
            end
            default: state_d = StReset;
        endcase
    end

    // Divider, half-period counter, gap counter and the SPI_CLK / ADC_Conv levels.
    always_comb begin
        state_chg = (state_d != state_q);
        div_d     = (!run_q || state_chg || tick) ? 8'd0 : div_q + 8'd1;
        cnt_d     = state_chg ? 7'd0 : (tick ? cnt_q + 7'd1 : cnt_q);
        gap_d     = (state_q == StGap && !state_chg) ? gap_q + GapW'(1) : '0;
        sclk_d    = sclk_toggle ? ~sclk_q : sclk_q;
        if (state_d != StShift && state_d != StAmpLoad) begin
            sclk_d = 1'b0;
        end
        conv_d    = (state_d == StConv);
    end

    // Output stream: publish, consume, and flag an overwrite of an unconsumed sample.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && smp.sample_ready) begin
            valid_d = 1'b0;
        end
        if (state_q == StPublish) begin
            data_d    = cap_q;
            valid_d   = 1'b1;
            overrun_d = valid_q && !smp.sample_ready;
        end
    end

    // Core state, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StReset;
            run_q     <= 1'b0;
            div_q     <= 8'd0;
            cnt_q     <= 7'd0;
            gap_q     <= '0;
            sclk_q    <= 1'b0;
            conv_q    <= 1'b0;
            cap_q     <= 14'd0;
            data_q    <= 14'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            sclk_q    <= sclk_d;
            conv_q    <= conv_d;
            cap_q     <= cap_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef ADC_AMP_INIT_EN
    logic       cs_q, cs_d;
    logic       mosi_q, mosi_d;
    logic [7:0] amp_sh_q, amp_sh_d;

    // Gain word shifts out MSB first; MOSI only moves when SPI_CLK falls.
    always_comb begin
        amp_sh_d = amp_sh_q;
        if (state_q == StAmpLoad && sclk_toggle && sclk_q) begin
            amp_sh_d = {amp_sh_q[6:0], 1'b0};
        end
        cs_d   = (state_d != StAmpLoad);
        mosi_d = (state_d == StAmpLoad) ? amp_sh_d[7] : 1'b0;
    end

    // Amplifier chip select, data line and gain shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q     <= 1'b1;
            mosi_q   <= 1'b0;
            amp_sh_q <= AMP_GAIN;
        end else begin
            cs_q     <= cs_d;
            mosi_q   <= mosi_d;
            amp_sh_q <= amp_sh_d;
        end
    end

    assign CS_AMP = cs_q;
    assign MOSI   = mosi_q;
`else
    logic unused_amp_gain;
    assign unused_amp_gain = ^AMP_GAIN;
    assign CS_AMP          = 1'b1;
    assign MOSI            = 1'b0;
`endif

    assign SPI_CLK          = sclk_q;
    assign ADC_Conv         = conv_q;
    assign smp.sample_data  = data_q;
    assign smp.sample_valid = valid_q;
    assign smp.overrun      = overrun_q;

endmodule

// File: doc/adc_spi_capture.md
Name: adc_spi_capture

Overview:
- SPI front end for the amplifier/ADC pair; sits directly upstream of the UART transmitter stage and feeds it 14-bit samples.
- After reset, optionally programs the programmable-gain amplifier over MOSI with CS_AMP low.
- Then runs conversion frames forever: pulses ADC_Conv, clocks 34 SPI_CLK cycles, and captures channel A from MISO.
- Presents each captured sample on a valid/ready handshake.

Parameters:
- CLK_DIV, 8: clk cycles per SPI_CLK half-period. Default gives 320 ns SPI_CLK at 50 MHz clk. Legal range 2..255.
- AMP_GAIN, 8'h11: 8-bit gain word shifted to the amplifier, MSB first.
- CONV_GAP, 100: idle clk cycles between end of one frame and the next ADC_Conv pulse. Legal range ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- MISO  in  1  ADC serial data
- MOSI  out  1  amplifier serial data
- SPI_CLK  out  1  shared serial clock, idles low
- CS_AMP  out  1  amplifier chip select, active-low
- ADC_Conv  out  1  ADC conversion strobe, active-high
- sample_data  out  14  channel A sample, two's complement, as received
- sample_valid  out  1  sample_data holds an unconsumed sample
- sample_ready  in  1  downstream (UART transmitter) accepts the sample
- overrun  out  1  one-cycle pulse: a new sample overwrote an unconsumed one

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - Outputs: CS_AMP=1, SPI_CLK=0, MOSI=0, ADC_Conv=0, sample_data=0, sample_valid=0, overrun=0.
  - Divider and bit counters cleared; FSM enters AMP_LOAD (or CONV if the macro is absent).
- Divider:
  - Tick every CLK_DIV clk cycles.
  - SPI_CLK toggles on a tick only in AMP_LOAD and SHIFT; otherwise it is held 0.
  - One SPI_CLK period = 2*CLK_DIV clk cycles.
- States: AMP_LOAD → AMP_END → CONV → SHIFT → PUBLISH → GAP → CONV.
- AMP_LOAD:
  - CS_AMP=0 one half-period before the first rising edge.
  - MOSI presents AMP_GAIN[7] first and changes only when SPI_CLK falls.
  - 8 SPI_CLK cycles total.
- AMP_END:
  - CS_AMP=1, MOSI=0, SPI_CLK=0.
  - Wait 2*CLK_DIV clk cycles, then go to CONV.
- CONV: ADC_Conv=1 for exactly 2*CLK_DIV clk cycles; SPI_CLK=0.
- SHIFT:
  - 34 SPI_CLK cycles, numbered 0..33.
  - MISO is sampled on the clk edge at which SPI_CLK is driven 1→0.
  - Bits 2..15 = channel A, MSB first, into sample_data[13:0].
  - Bits 0,1 and 16..33 are discarded (channel B is ignored).
  - CS_AMP=1 and MOSI=0 throughout.
- PUBLISH (1 clk):
  - Load sample_data and set sample_valid=1.
  - If sample_valid was already 1 and not accepted this cycle: overwrite sample_data, keep valid=1, assert overrun for this cycle.
- GAP: CONV_GAP clk cycles, then CONV.
- Handshake:
  - Transfer occurs on a clk edge with sample_valid=1 and sample_ready=1; sample_valid clears next cycle.
  - sample_data is stable while sample_valid=1, except on an overrun.
  - sample_ready while sample_valid=0 is ignored.
  - Simultaneous accept and PUBLISH: the new sample loads, valid stays 1, no overrun.
- Frame period: (2+68)*CLK_DIV + 1 + CONV_GAP clk cycles, i.e. 661 at defaults.
- First sample_valid rise after reset release (macro on): amp phase 16*CLK_DIV + CLK_DIV setup + 2*CLK_DIV end, then conversion. Bench checks ±1 cycle.

Optional Feature:
- Macro: ADC_AMP_INIT_EN.
- Defined: the AMP_LOAD/AMP_END sequence runs once after every reset, before the first CONV.
- Undefined: FSM resets directly into CONV. CS_AMP is held 1 and MOSI 0 permanently. The AMP_LOAD/AMP_END logic is not synthesised.

Test Plan:
- Reset with macro defined:
  - CS_AMP falls once.
  - Exactly 8 SPI_CLK rising edges while low.
  - MOSI bits at those edges read 0x11.
  - CS_AMP returns to 1 before ADC_Conv first rises.
- Model drives MISO 3 ns after each SPI_CLK rise, channel A = 14'h2A5C in bits 2..15, channel B random:
  - sample_data = 14'h2A5C, sample_valid=1.
  - ADC_Conv high 16 clk; 34 SPI_CLK edges per frame.
- sample_ready held 1, three frames with A = 14'h0001, 14'h3FFF, 14'h2000:
  - three valid pulses with matching data in order, overrun never asserted.
  - Frame spacing 661 clk.
- sample_ready held 0 across two frames:
  - overrun pulses exactly 1 cycle at the second PUBLISH.
  - sample_data shows the second value; valid stays 1 until ready=1.
- Assert rst mid-SHIFT (bit 20):
  - All outputs take reset values asynchronously, within the same clk period.
  - After release, the sequence restarts from AMP_LOAD and no partial sample is published.
- Build without ADC_AMP_INIT_EN:
  - CS_AMP constantly 1.
  - First ADC_Conv rises on the first clk edge after reset release.
